// File: rtl/if_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_unit_pkg                                                     |
// | Purpose  : Shared constants and types for the fetch stage: the NOP word,   |
// |            instruction field bit positions, FSM state encodings, the       |
// |            IF/ID write command and the instruction field split helper.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package if_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RD_MSB     = 25;
  localparam int RD_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RS_MSB     = 15;
  localparam int RS_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int IIMM_MSB   = 15;
  localparam int JIMM_MSB   = 25;
  localparam int AIMM_MSB   = 20;

  // Fetch FSM encodings
  localparam logic [0:0] S_BOOT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // What the IF/ID register does on the coming edge
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_cmd_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [4:0]  rs;
    logic [4:0]  shamt;
    logic [15:0] i_imm;
    logic [25:0] j_imm;
    logic [20:0] a_imm;
  } fields_t;

  function automatic fields_t split_instr(input logic [31:0] instr);
    fields_t f;
    f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.rt     = instr[RT_MSB:RT_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    f.i_imm  = instr[IIMM_MSB:0];
    f.j_imm  = instr[JIMM_MSB:0];
    f.a_imm  = instr[AIMM_MSB:0];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_unit_if                                                      |
// | Purpose  : Bundle of all fetch-stage signals other than clk/rst.           |
// |            master = the fetch unit, slave = its environment (hazard unit,  |
// |            branch logic, instruction memory, decode stage).                |
// | Signals  : stall, flush, redirect, redirect_pc   control into fetch        |
// |            imem_addr / imem_rdata                instruction memory bus    |
// |            instr_valid, opcode .. A_type_imm     IF/ID contents            |
// |            PC_out                                PC+1 of IF/ID instruction |
// |            perf_fetch_cnt, perf_bubble_cnt       performance counters      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface if_unit_if #(
  parameter int IMEM_ADDR_W = 16
);

  logic                   stall;
  logic                   flush;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;
  logic                   instr_valid;
  logic [5:0]             opcode;
  logic [4:0]             R_I_A_type_rd;
  logic [4:0]             R_type_rt;
  logic [4:0]             R_I_type_rs;
  logic [4:0]             R_type_shamt;
  logic [15:0]            I_type_imm;
  logic [25:0]            J_type_imm;
  logic [20:0]            A_type_imm;
  logic [31:0]            PC_out;
  logic [31:0]            perf_fetch_cnt;
  logic [31:0]            perf_bubble_cnt;

  modport master (
    input  stall, flush, redirect, redirect_pc, imem_rdata,
    output imem_addr, instr_valid, opcode, R_I_A_type_rd, R_type_rt,
           R_I_type_rs, R_type_shamt, I_type_imm, J_type_imm, A_type_imm,
           PC_out, perf_fetch_cnt, perf_bubble_cnt
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, imem_rdata,
    input  imem_addr, instr_valid, opcode, R_I_A_type_rd, R_type_rt,
           R_I_type_rs, R_type_shamt, I_type_imm, J_type_imm, A_type_imm,
           PC_out, perf_fetch_cnt, perf_bubble_cnt
  );

endinterface
`default_nettype wire

// File: rtl/if_unit_ifid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_unit_ifid_reg                                                |
// | Purpose  : IF/ID pipeline register. On LOAD captures the fetched word and  |
// |            its PC+1 and marks it valid; on BUBBLE writes a NOP, clears     |
// |            valid and keeps pc_out; on HOLD keeps everything.               |
// | Ports    : clk, rst (async, active-low)                                    |
// |            cmd          in   write command for this edge                   |
// |            instr_in     in   32  word returned by instruction memory       |
// |            pc_in        in   32  PC+1 belonging to instr_in                |
// |            instr_valid  out  1   register holds a real instruction         |
// |            pc_out       out  32  PC+1 of the held instruction              |
// |            fields       out      held word split into its fields           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module if_unit_ifid_reg
  import if_unit_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire ifid_cmd_t   cmd,
  input  wire logic [31:0] instr_in,
  input  wire logic [31:0] pc_in,
  output logic             instr_valid,
  output logic [31:0]      pc_out,
  output fields_t          fields
);

  logic [31:0] instr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q     <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc_out      <= 32'h0;
    end else begin
      case (cmd)
        IFID_LOAD: begin
          instr_q     <= instr_in;
          instr_valid <= 1'b1;
          pc_out      <= pc_in;
        end
        IFID_BUBBLE: begin
          // pc_out deliberately left alone
          instr_q     <= NOP_INSTR;
          instr_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign fields = split_instr(instr_q);

endmodule
`default_nettype wire

// File: rtl/if_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_unit                                                         |
// | Purpose  : Fetch stage plus IF/ID register. Owns the PC, drives the        |
// |            synchronous instruction memory (1-cycle read latency) and       |
// |            handles stall, flush and redirect.                              |
// | Params   : RESET_PC     first fetch address after reset release           |
// |            IMEM_ADDR_W  instruction memory address width                   |
// | Ports    : clk  in  rising-edge clock                                      |
// |            rst  in  asynchronous reset, active-low                         |
// |            bus  if_unit_if.master  control, imem bus, IF/ID outputs        |
// | Config   : IF_PERF_CNT_EN  when defined, perf_fetch_cnt/perf_bubble_cnt    |
// |            count valid / bubble IF/ID writes; otherwise both tie to 0.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module if_unit
  import if_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          IMEM_ADDR_W = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  if_unit_if.master   bus
);

  logic [0:0]  state;
  logic [31:0] fetch_pc;   // address issued on the previous cycle
  logic        fetch_vld;  // imem_rdata holds a wanted word
  logic [31:0] pc_inc;
  logic [31:0] next_addr;  // address issued this cycle, becomes fetch_pc
  ifid_cmd_t   cmd;
  fields_t     fields;

  assign pc_inc = fetch_pc + 32'd1;

  // Priority redirect > stall > advance. During a stall the current
  // address is re-issued so imem_rdata stays stable for the release edge.
  always_comb begin
    next_addr = pc_inc;
    cmd       = IFID_HOLD;
    if (state == S_BOOT) begin
      next_addr = RESET_PC;
      cmd       = IFID_BUBBLE;
    end else if (bus.redirect) begin
      next_addr = bus.redirect_pc;
      cmd       = IFID_BUBBLE;
    end else if (bus.stall) begin
      next_addr = fetch_pc;
      cmd       = bus.flush ? IFID_BUBBLE : IFID_HOLD;
    end else begin
      next_addr = pc_inc;
      cmd       = (fetch_vld && !bus.flush) ? IFID_LOAD : IFID_BUBBLE;
    end
  end

  assign bus.imem_addr = next_addr[IMEM_ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BOOT;
      fetch_pc  <= RESET_PC;
      fetch_vld <= 1'b0;
    end else begin
      state    <= S_RUN;
      fetch_pc <= next_addr;
      if (state == S_BOOT || bus.redirect) begin
        fetch_vld <= 1'b1;
      end
    end
  end

  if_unit_ifid_reg u_ifid (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .instr_in    (bus.imem_rdata),
    .pc_in       (pc_inc),
    .instr_valid (bus.instr_valid),
    .pc_out      (bus.PC_out),
    .fields      (fields)
  );

  assign bus.opcode        = fields.opcode;
  assign bus.R_I_A_type_rd = fields.rd;
  assign bus.R_type_rt     = fields.rt;
  assign bus.R_I_type_rs   = fields.rs;
  assign bus.R_type_shamt  = fields.shamt;
  assign bus.I_type_imm    = fields.i_imm;
  assign bus.J_type_imm    = fields.j_imm;
  assign bus.A_type_imm    = fields.a_imm;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (cmd == IFID_LOAD) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (cmd == IFID_BUBBLE) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end

  assign bus.perf_fetch_cnt  = fetch_cnt;
  assign bus.perf_bubble_cnt = bubble_cnt;
`else
  assign bus.perf_fetch_cnt  = 32'h0;
  assign bus.perf_bubble_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_if_unit                                                      |
// | Purpose  : Directed self-checking bench for if_unit: reset, streaming,     |
// |            stall, redirect (plain and with stall), flush, PC wrap,         |
// |            performance counters (IF_PERF_CNT_EN) and mid-run reset.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_if_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] hi_tag = 16'h0;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  if_unit_if #(.IMEM_ADDR_W(16)) bus ();

  if_unit #(.RESET_PC(32'h0), .IMEM_ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory content: low half = addr + 0x100, upper half = hi_tag
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {hi_tag, 16'h0} + {16'h0, a} + 32'h100;
  endfunction

  // Synchronous instruction memory, 1-cycle read latency
  always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] w, input logic [31:0] pc);
    chk({tag, ".valid"},  64'(bus.instr_valid),   64'd1);
    chk({tag, ".opcode"}, 64'(bus.opcode),        64'(w[31:26]));
    chk({tag, ".rd"},     64'(bus.R_I_A_type_rd), 64'(w[25:21]));
    chk({tag, ".rt"},     64'(bus.R_type_rt),     64'(w[20:16]));
    chk({tag, ".rs"},     64'(bus.R_I_type_rs),   64'(w[15:11]));
    chk({tag, ".shamt"},  64'(bus.R_type_shamt),  64'(w[10:6]));
    chk({tag, ".iimm"},   64'(bus.I_type_imm),    64'(w[15:0]));
    chk({tag, ".jimm"},   64'(bus.J_type_imm),    64'(w[25:0]));
    chk({tag, ".aimm"},   64'(bus.A_type_imm),    64'(w[20:0]));
    chk({tag, ".pc"},     64'(bus.PC_out),        64'(pc));
  endtask

  task automatic check_nop(input string tag);
    chk({tag, ".valid"},  64'(bus.instr_valid),   64'd0);
    chk({tag, ".opcode"}, 64'(bus.opcode),        64'd0);
    chk({tag, ".rd"},     64'(bus.R_I_A_type_rd), 64'd0);
    chk({tag, ".rt"},     64'(bus.R_type_rt),     64'd0);
    chk({tag, ".shamt"},  64'(bus.R_type_shamt),  64'd0);
    chk({tag, ".jimm"},   64'(bus.J_type_imm),    64'd0);
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // T1: reset held 5 cycles
    repeat (5) tick();
    chk("t1.addr", 64'(bus.imem_addr), 64'h0);
    check_nop("t1.rst");
    chk("t1.pc",     64'(bus.PC_out),          64'h0);
    chk("t1.pfetch", 64'(bus.perf_fetch_cnt),  64'h0);
    chk("t1.pbub",   64'(bus.perf_bubble_cnt), 64'h0);
    rst = 1'b1;
    #1;
    chk("t1.bootaddr", 64'(bus.imem_addr), 64'h0);
    tick();                                   // edge 1: boot bubble
    chk("t1.e1valid", 64'(bus.instr_valid), 64'd0);
    chk("t1.e1addr",  64'(bus.imem_addr),   64'h1);
    tick();                                   // edge 2: first valid word
    check_word("t1.e2", 32'h100, 32'h1);

    // T2: streaming
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_word("t2.stream", 32'h100 + 32'(k), 32'(k + 1));
    end

    // T3: stall 3 cycles with fetch_pc = 5
    bus.stall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t3.addr", 64'(bus.imem_addr), 64'h5);
      tick();
      check_word("t3.hold", 32'h104, 32'h5);
    end
    chk("t3.addr_last", 64'(bus.imem_addr), 64'h5);
    bus.stall = 1'b0;
    #1;
    chk("t3.addr_rel", 64'(bus.imem_addr), 64'h6);
    tick();
    check_word("t3.res5", 32'h105, 32'h6);
    tick();
    check_word("t3.res6", 32'h106, 32'h7);

    // T4: redirect to 0x40 with fetch_pc = 7
    hi_tag = 16'hA5C3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    chk("t4.addr", 64'(bus.imem_addr), 64'h40);
    tick();
    check_nop("t4.bub");
    chk("t4.bubpc", 64'(bus.PC_out), 64'h7);
    bus.redirect = 1'b0;
    #1;
    chk("t4.addr2", 64'(bus.imem_addr), 64'h41);
    tick();
    check_word("t4.tgt", 32'hA5C3_0140, 32'h41);
    // same with stall asserted
    bus.redirect    = 1'b1;
    bus.stall       = 1'b1;
    bus.redirect_pc = 32'h80;
    #1;
    chk("t4s.addr", 64'(bus.imem_addr), 64'h80);
    tick();
    check_nop("t4s.bub");
    chk("t4s.bubpc", 64'(bus.PC_out), 64'h41);
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    tick();
    check_word("t4s.tgt", 32'hA5C3_0180, 32'h81);

    // T5: flush without stall, then flush with stall
    bus.flush = 1'b1;
    tick();
    check_nop("t5.flush");
    bus.flush = 1'b0;
    tick();
    check_word("t5.next", 32'hA5C3_0182, 32'h83);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    #1;
    chk("t5s.addr", 64'(bus.imem_addr), 64'h83);
    tick();
    check_nop("t5s.flush");
    bus.flush = 1'b0;
    tick();
    check_nop("t5s.hold");
    chk("t5s.addr2", 64'(bus.imem_addr), 64'h83);
    bus.stall = 1'b0;
    tick();
    check_word("t5s.res", 32'hA5C3_0183, 32'h84);

    // T6: wrap through 32'hFFFFFFFF
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    #1;
    chk("t6.addr", 64'(bus.imem_addr), 64'hFFFF);
    tick();
    check_nop("t6.bub");
    bus.redirect = 1'b0;
    #1;
    chk("t6.addrwrap", 64'(bus.imem_addr), 64'h0);
    tick();
    check_word("t6.top", 32'hA5C4_00FF, 32'h0);
    chk("t6.addr1", 64'(bus.imem_addr), 64'h1);
    tick();
    check_word("t6.zero", 32'hA5C3_0100, 32'h1);

    // Counters: 13 valid writes, 6 bubbles since reset release
`ifdef IF_PERF_CNT_EN
    chk("perf.fetch",  64'(bus.perf_fetch_cnt),  64'd13);
    chk("perf.bubble", 64'(bus.perf_bubble_cnt), 64'd6);
`else
    chk("perf.fetch",  64'(bus.perf_fetch_cnt),  64'd0);
    chk("perf.bubble", 64'(bus.perf_bubble_cnt), 64'd0);
`endif

    // Mid-run asynchronous reset
    #2;
    rst = 1'b0;
    #1;
    check_nop("rst2");
    chk("rst2.pc",     64'(bus.PC_out),          64'h0);
    chk("rst2.addr",   64'(bus.imem_addr),       64'h0);
    chk("rst2.pfetch", 64'(bus.perf_fetch_cnt),  64'h0);
    chk("rst2.pbub",   64'(bus.perf_bubble_cnt), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
